// File: rtl/sparq_pkg.sv
// rtl/sparq_pkg.sv - shared types and default geometry for the MXU feed sequencer
package sparq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_PIPE_LAT = 2;
  localparam int unsigned DEF_KW       = 10;

  // One spare bit so the terminal drain count never aliases to zero.
  function automatic int unsigned drain_cnt_w(input int unsigned rows, input int unsigned pipe_lat);
    return $clog2(rows + pipe_lat) + 1;
  endfunction

endpackage

// File: rtl/mxu_feed_sequencer_if.sv
// rtl/mxu_feed_sequencer_if.sv - tile request and systolic feed signals of the MXU feed sequencer
interface mxu_feed_sequencer_if
  import sparq_pkg::*;
#(
  parameter int ROWS = int'(DEF_ROWS),
  parameter int KW   = int'(DEF_KW)
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            stall;
  logic            busy;
  logic            feed_valid;
  logic [KW-1:0]   feed_idx;
  logic [ROWS-1:0] row_en;
  logic            flush;
  logic            done;

  modport master (
    output start, k_len, stall,
    input  busy, feed_valid, feed_idx, row_en, flush, done
  );

  modport slave (
    input  start, k_len, stall,
    output busy, feed_valid, feed_idx, row_en, flush, done
  );
endinterface

// File: rtl/mxu_skew_chain.sv
// rtl/mxu_skew_chain.sv - stall-aware delay chain producing the diagonal row enables
module mxu_skew_chain #(
  parameter int STAGES = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en_i,
  input  logic              din_i,
  output logic [STAGES-1:0] taps_o
);
  logic [STAGES-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (shift_en_i) begin
      chain_d[0] = din_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_d[i] = chain_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign taps_o = chain_q;
endmodule

// File: rtl/mxu_feed_sequencer.sv
// rtl/mxu_feed_sequencer.sv - issues k_len feed vectors, drains the array, then pulses done
module mxu_feed_sequencer
  import sparq_pkg::*;
#(
  parameter int ROWS     = int'(DEF_ROWS),
  parameter int PIPE_LAT = int'(DEF_PIPE_LAT),
  parameter int KW       = int'(DEF_KW)
) (
  input  logic                  clk,
  input  logic                  rst,
  mxu_feed_sequencer_if.slave   bus
);
  localparam int DRAIN_LEN = ROWS - 1 + PIPE_LAT;
  localparam int DCW       = int'(drain_cnt_w(ROWS, PIPE_LAT));
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

  seq_state_e      state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            feed_valid;
  logic            flush;
  logic            last_feed;
  logic [ROWS-1:0] row_en_raw;

  assign last_feed = (idx_q == (k_len_q - KW'(1)));

  always_comb begin
    state_d    = state_q;
    k_len_d    = k_len_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    feed_valid = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stall) begin
          k_len_d = bus.k_len;
          idx_d   = '0;
          drain_d = '0;
          state_d = (bus.k_len == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        if (!bus.stall) begin
          feed_valid = 1'b1;
          if (last_feed) begin
            idx_d   = '0;
            state_d = (DRAIN_LEN == 0) ? ST_DONE : ST_DRAIN;
          end else begin
            idx_d = idx_q + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!bus.stall) begin
          flush = 1'b1;
          if (drain_q == DRAIN_LAST) begin
            drain_d = '0;
            state_d = ST_DONE;
          end else begin
            drain_d = drain_q + DCW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_len_q <= '0;
      idx_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  // Row 0 sees the live feed; deeper rows see it delayed by their row index.
  generate
    if (ROWS > 1) begin : g_skew
      logic [ROWS-2:0] taps;
      mxu_skew_chain #(.STAGES(ROWS - 1)) u_skew (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (!bus.stall),
        .din_i      (feed_valid),
        .taps_o     (taps)
      );
      assign row_en_raw = {taps, feed_valid};
    end else begin : g_noskew
      assign row_en_raw = feed_valid;
    end
  endgenerate

  assign bus.busy       = (state_q != ST_IDLE) && !rst;
  assign bus.feed_valid = feed_valid && !rst;
  assign bus.feed_idx   = idx_q & {KW{!rst}};
  assign bus.row_en     = row_en_raw & {ROWS{!bus.stall && !rst}};
  assign bus.flush      = flush && !rst;
  assign bus.done       = (state_q == ST_DONE) && !rst;
endmodule

// File: tb/tb_mxu_feed_sequencer.sv
// tb/tb_mxu_feed_sequencer.sv - directed timing scenarios plus random traffic against a queue-based model
module tb_mxu_feed_sequencer;
  localparam int ROWS     = 4;
  localparam int PIPE_LAT = 2;
  localparam int KW       = 10;
  localparam int DL       = ROWS - 1 + PIPE_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mxu_feed_sequencer_if #(.ROWS(ROWS), .KW(KW)) bus ();

  mxu_feed_sequencer #(.ROWS(ROWS), .PIPE_LAT(PIPE_LAT), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit m_active      = 1'b0;
  int m_feeds_left  = 0;
  int m_drain_left  = 0;
  int m_next_idx    = 0;
  bit m_hist[$];

  logic [17:0]     exp_v, obs_v;
  logic            o_busy, o_fv, o_flush, o_done;
  logic [KW-1:0]   o_idx;
  logic [ROWS-1:0] o_row;

  function automatic logic [17:0] model_out(input bit r, input bit s);
    logic [ROWS-1:0] re;
    bit fv, fl, dn, by;
    int idx;
    if (r) return '0;
    by  = m_active;
    fv  = m_active && (m_feeds_left > 0) && !s;
    idx = (m_active && m_feeds_left > 0) ? m_next_idx : 0;
    fl  = m_active && (m_feeds_left == 0) && (m_drain_left > 0) && !s;
    dn  = m_active && (m_feeds_left == 0) && (m_drain_left == 0);
    re[0] = fv;
    for (int i = 1; i < ROWS; i++) re[i] = !s && m_hist[i-1];
    return {by, fv, KW'(idx), re, fl, dn};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit st, input int k, input bit fv);
    if (r) begin
      m_active = 1'b0; m_feeds_left = 0; m_drain_left = 0; m_next_idx = 0;
      for (int i = 0; i < ROWS - 1; i++) m_hist[i] = 1'b0;
      return;
    end
    if (!s) begin
      m_hist.push_front(fv);
      void'(m_hist.pop_back());
    end
    if (!m_active) begin
      if (st && !s) begin
        m_active = 1'b1; m_feeds_left = k; m_next_idx = 0;
        m_drain_left = (k == 0) ? 0 : DL;
      end
    end else if (m_feeds_left > 0) begin
      if (!s) begin m_feeds_left--; m_next_idx++; end
    end else if (m_drain_left > 0) begin
      if (!s) m_drain_left--;
    end else begin
      m_active = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit st, input bit s, input logic [KW-1:0] k);
    rst = r; bus.start = st; bus.stall = s; bus.k_len = k;
    exp_v = model_out(r, s);
    @(negedge clk);
    o_busy = bus.busy; o_fv = bus.feed_valid; o_idx = bus.feed_idx;
    o_row = bus.row_en; o_flush = bus.flush; o_done = bus.done;
    obs_v = {o_busy, o_fv, o_idx, o_row, o_flush, o_done};
    @(posedge clk);
    model_step(r, s, st, int'(k), exp_v[16]);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 1'b1, 1'b1, 10'd5);
      vectors++;
      if (obs_v !== 18'h0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc %0d: got %h want %h", c, obs_v, 18'h0);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 10'd0);
    vectors++;
    if (obs_v !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", obs_v, 18'h0);
    end
  endtask

  task automatic test_basic();
    logic [4:0] want;
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, c == 0, 1'b0, (c == 0) ? 10'd3 : 10'($urandom));
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL basic_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
      want = {c >= 1 && c <= 3, c >= 4 && c <= 6, c >= 4 && c <= 8, c == 9, c >= 1 && c <= 9};
      vectors++;
      if ({o_fv, o_row[3], o_flush, o_done, o_busy} !== want) begin
        miscompares++;
        $display("FAIL basic_timing cyc %0d: got fv/row3/flush/done/busy %b want %b", c,
                 {o_fv, o_row[3], o_flush, o_done, o_busy}, want);
      end
      if (c >= 1 && c <= 3) begin
        vectors++;
        if (o_idx !== KW'(c - 1)) begin
          miscompares++;
          $display("FAIL basic_idx cyc %0d: got %0d want %0d", c, o_idx, c - 1);
        end
      end
    end
  endtask

  task automatic test_zero();
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, c == 0, 1'b0, 10'd0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL zero_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
      vectors++;
      if ({o_done, o_busy, o_fv, o_row} !== {c == 1, c == 1, 1'b0, 4'b0}) begin
        miscompares++;
        $display("FAIL zero_timing cyc %0d: got done/busy/fv/row %b want %b", c,
                 {o_done, o_busy, o_fv, o_row}, {c == 1, c == 1, 1'b0, 4'b0});
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0] want;
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 13; c++) begin
      cycle(1'b0, c == 0, c == 2, 10'd3);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL stall_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
      want = {c == 1 || c == 3 || c == 4, c == 10, c >= 1 && c <= 10};
      vectors++;
      if ({o_fv, o_done, o_busy} !== want) begin
        miscompares++;
        $display("FAIL stall_timing cyc %0d: got fv/done/busy %b want %b", c, {o_fv, o_done, o_busy}, want);
      end
      if (c == 2) begin
        vectors++;
        if (o_row !== 4'b0) begin
          miscompares++;
          $display("FAIL stall_row_en: got %b want 0000", o_row);
        end
      end
      if (c == 3) begin
        vectors++;
        if (o_idx !== 10'd1) begin
          miscompares++;
          $display("FAIL stall_idx: got %0d want 1", o_idx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] want;
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 15; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 10'd3);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
      want = {(c >= 1 && c <= 3) || (c >= 11 && c <= 13), c == 9, (c >= 1 && c <= 9) || c >= 11};
      vectors++;
      if ({o_fv, o_done, o_busy} !== want) begin
        miscompares++;
        $display("FAIL b2b_timing cyc %0d: got fv/done/busy %b want %b", c, {o_fv, o_done, o_busy}, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 9; c++) begin
      cycle(c == 5, c == 0 || c == 6, 1'b0, 10'd3);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rstmid_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
      vectors++;
      if (o_done !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_no_done cyc %0d: got %b want 0", c, o_done);
      end
      if (c == 5 || c == 6) begin
        vectors++;
        if (obs_v !== 18'h0) begin
          miscompares++;
          $display("FAIL rstmid_zero cyc %0d: got %h want 0", c, obs_v);
        end
      end
      if (c == 7) begin
        vectors++;
        if ({o_fv, o_idx} !== {1'b1, 10'd0}) begin
          miscompares++;
          $display("FAIL rstmid_restart: got fv %b idx %0d want fv 1 idx 0", o_fv, o_idx);
        end
      end
    end
  endtask

  task automatic test_max();
    int last_idx = -1;
    int feeds    = 0;
    int done_cyc = -1;
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 1100 && done_cyc < 0; c++) begin
      cycle(1'b0, c == 0, 1'b0, 10'd1023);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL max_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
      if (o_fv === 1'b1) begin feeds++; last_idx = int'(o_idx); end
      if (o_done === 1'b1) done_cyc = c;
    end
    vectors++;
    if (last_idx !== 1022 || feeds !== 1023) begin
      miscompares++;
      $display("FAIL max_last_idx: got idx %0d feeds %0d want idx 1022 feeds 1023", last_idx, feeds);
    end
    vectors++;
    if (done_cyc !== 1 + 1023 + DL) begin
      miscompares++;
      $display("FAIL max_done_cycle: got %0d want %0d", done_cyc, 1 + 1023 + DL);
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] k;
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int c = 0; c < 600; c++) begin
      k = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 7));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, k);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL random_model cyc %0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.k_len = '0;
    for (int i = 0; i < ROWS - 1; i++) m_hist.push_back(1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/mxu_feed_sequencer.md
MXU_FEED_SEQUENCER -- requirements
Module: mxu_feed_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 8: systolic rows, equal to the input-skew depth.
REQ-002 SHALL have parameter PIPE_LAT, default 2: fixed delay-line latency in cycles (FIFO CYCLES).
REQ-003 SHALL have parameter KW, default 10: width of the vector-count field.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: tile request, sampled only in IDLE.
REQ-007 SHALL have port k_len, input, KW: number of feed vectors, latched on start acceptance.
REQ-008 SHALL have port stall, input, 1: freeze sequencing for this cycle.
REQ-009 SHALL have port busy, output, 1: high in FEED, DRAIN and DONE.
REQ-010 SHALL have port feed_valid, output, 1: a vector is presented to row 0 this cycle.
REQ-011 SHALL have port feed_idx, output, KW: index of the current feed vector.
REQ-012 SHALL have port row_en, output, ROWS: skewed per-row enable.
REQ-013 SHALL have port flush, output, 1: high in DRAIN while not stalled.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, FEED, DRAIN and DONE.
REQ-016 SHALL, in IDLE with start=1, latch k_len and go to FEED, or to DONE if k_len==0; no feed occurs for k_len==0.
REQ-017 SHALL ignore start in every state except IDLE, including the DONE cycle.
REQ-018 SHALL set feed_valid = (state==FEED && !stall); feed_idx counts 0..k_len-1 and increments only on feed_valid.
REQ-019 SHALL move FEED -> DRAIN on the cycle that issues feed_idx==k_len-1 with feed_valid=1.
REQ-020 SHALL hold DRAIN for exactly ROWS-1+PIPE_LAT non-stalled cycles, then go to DONE.
REQ-021 SHALL hold DONE for exactly one cycle (done=1, busy=1), then go to IDLE, regardless of stall.
REQ-022 SHALL drive row_en[0] = feed_valid.
REQ-023 SHALL drive row_en[r], for r>0, equal to feed_valid from r non-stalled cycles earlier, using a skew register that shifts only when stall=0.
REQ-024 SHALL force row_en to all zeros during stall; the skew register, counters and state all hold.
REQ-025 SHALL compute the drain counter at width clog2(ROWS+PIPE_LAT)+1; k_len=2^KW-1 SHALL work without feed_idx wrap-around before the exit.
REQ-026 SHALL, when stall is asserted in the same cycle as the final feed, suppress that feed and retry it on the next non-stalled cycle.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set state to IDLE and clear feed_idx, the drain counter, the skew register and latched k_len.
REQ-028 SHALL hold the following outputs at 0 while in reset: busy, feed_valid, feed_idx, row_en, flush and done.
REQ-029 SHALL, on reset mid-tile, abandon the tile: no done pulse, and the next start begins a fresh tile.
REQ-030 SHALL give rst priority over start and stall in the same cycle.

Structure
REQ-031 SHALL place the state enum type and the default values of ROWS and PIPE_LAT in SPARQ_PKG.
REQ-032 SHALL use registered state and counters with combinational next-state logic.
REQ-033 SHALL implement the skew register as one sub-module, mxu_skew_chain, with ROWS-1 stages and a shift enable.

Verification
REQ-034 SHALL cover, with ROWS=4, PIPE_LAT=2, k_len=3 and start at cycle 0: feed_valid in cycles 1-3 with feed_idx 0,1,2; row_en[3] in cycles 4-6; flush in cycles 4-8; done in cycle 9; busy in cycles 1-9.
REQ-035 SHALL cover k_len=0 with start at cycle 0: done in cycle 1, feed_valid never high, row_en all 0.
REQ-036 SHALL cover the REQ-034 setup plus stall in cycle 2: feed_idx 1 moves to cycle 3, row_en=0 in cycle 2, and done moves to cycle 10.
REQ-037 SHALL cover start=1 held continuously: a second tile starts at cycle 10 (first FEED in cycle 11), and no start is accepted in cycles 1-9.
REQ-038 SHALL cover rst asserted in cycle 5 of the REQ-034 setup: cycle 6 is IDLE with all outputs 0, no done pulse, and a new start is accepted in cycle 6.
REQ-039 SHALL cover k_len=1023 (KW=10): feed_idx ends at 1022, and done arrives exactly 1+1023+5 cycles after start.
